// File: rtl/vnp4_axil_timeout_guard.sv
// AXI4-lite pass-through guard: one outstanding write and read, SLVERR on slave timeout, late responses absorbed.
// Optional VNP4_AXIL_GUARD_STATS_EN adds saturating timeout/orphan event counters.
module vnp4_axil_timeout_guard #(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_10CC
) (
  input  logic                    axi_aclk,
  input  logic                    axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
`ifdef VNP4_AXIL_GUARD_STATS_EN
  output logic [15:0]             wr_timeout_cnt,
  output logic [15:0]             rd_timeout_cnt,
  output logic [15:0]             orphan_cnt,
`endif
  output logic                    wr_timeout,
  output logic                    rd_timeout
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] TO_RDATA = DATA_WIDTH'(TIMEOUT_RDATA);

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP, W_ORPHAN} wst_e;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_RESP, R_ORPHAN} rst_e;

  wst_e                    wst_q, wst_d;
  rst_e                    rst_q, rst_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                    awv_q, awv_d, wv_q, wv_d, arv_q, arv_d;
  logic                    bv_q, bv_d, rv_q, rv_d;
  logic [1:0]              bresp_q, bresp_d, rresp_q, rresp_d;
  logic                    worph_q, worph_d, rorph_q, rorph_d;
  logic [CW-1:0]           wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic                    wto_q, wto_d, rto_q, rto_d;
  logic                    w_acc, r_acc;

  // Upstream ready is gated by reset so nothing is accepted while reset is held.
  assign w_acc = (wst_q == W_IDLE) && s_axi_awvalid && s_axi_wvalid && !axi_areset;
  assign r_acc = (rst_q == R_IDLE) && s_axi_arvalid && !axi_areset;

  assign s_axi_awready = w_acc;
  assign s_axi_wready  = w_acc;
  assign s_axi_arready = r_acc;
  assign s_axi_bvalid  = bv_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rv_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awv_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wv_q;
  assign m_axi_bready  = (wst_q == W_ISSUE) || (wst_q == W_ORPHAN);
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arv_q;
  assign m_axi_rready  = (rst_q == R_ISSUE) || (rst_q == R_ORPHAN);
  assign wr_timeout    = wto_q;
  assign rd_timeout    = rto_q;

  always_comb begin
    wst_d    = wst_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    awv_d    = awv_q && !m_axi_awready;
    wv_d     = wv_q && !m_axi_wready;
    bv_d     = bv_q;
    bresp_d  = bresp_q;
    worph_d  = worph_q;
    wcnt_d   = wcnt_q;
    wto_d    = 1'b0;
    case (wst_q)
      W_IDLE: if (w_acc) begin
        awaddr_d = s_axi_awaddr;
        wdata_d  = s_axi_wdata;
        wstrb_d  = s_axi_wstrb;
        awv_d    = 1'b1;
        wv_d     = 1'b1;
        wcnt_d   = '0;
        worph_d  = 1'b0;
        wst_d    = W_ISSUE;
      end
      W_ISSUE: begin
        wcnt_d = (wcnt_q == CNT_MAX) ? wcnt_q : wcnt_q + 1'b1;
        // A response landing in the final cycle wins over the timeout.
        if (m_axi_bvalid) begin
          bresp_d = m_axi_bresp;
          bv_d    = 1'b1;
          wst_d   = W_RESP;
        end else if (wcnt_q == CNT_LAST) begin
          bresp_d = 2'b10;
          bv_d    = 1'b1;
          worph_d = 1'b1;
          wto_d   = 1'b1;
          wst_d   = W_RESP;
        end
      end
      W_RESP: if (s_axi_bready) begin
        bv_d  = 1'b0;
        wst_d = worph_q ? W_ORPHAN : W_IDLE;
      end
      W_ORPHAN: if (m_axi_bvalid) wst_d = W_IDLE;
      default: wst_d = W_IDLE;
    endcase
  end

  always_comb begin
    rst_d    = rst_q;
    araddr_d = araddr_q;
    arv_d    = arv_q && !m_axi_arready;
    rv_d     = rv_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rorph_d  = rorph_q;
    rcnt_d   = rcnt_q;
    rto_d    = 1'b0;
    case (rst_q)
      R_IDLE: if (r_acc) begin
        araddr_d = s_axi_araddr;
        arv_d    = 1'b1;
        rcnt_d   = '0;
        rorph_d  = 1'b0;
        rst_d    = R_ISSUE;
      end
      R_ISSUE: begin
        rcnt_d = (rcnt_q == CNT_MAX) ? rcnt_q : rcnt_q + 1'b1;
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          rresp_d = m_axi_rresp;
          rv_d    = 1'b1;
          rst_d   = R_RESP;
        end else if (rcnt_q == CNT_LAST) begin
          rdata_d = TO_RDATA;
          rresp_d = 2'b10;
          rv_d    = 1'b1;
          rorph_d = 1'b1;
          rto_d   = 1'b1;
          rst_d   = R_RESP;
        end
      end
      R_RESP: if (s_axi_rready) begin
        rv_d  = 1'b0;
        rst_d = rorph_q ? R_ORPHAN : R_IDLE;
      end
      R_ORPHAN: if (m_axi_rvalid) rst_d = R_IDLE;
      default: rst_d = R_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      wst_q <= W_IDLE;  rst_q <= R_IDLE;
      awaddr_q <= '0;   araddr_q <= '0;
      wdata_q <= '0;    rdata_q <= '0;   wstrb_q <= '0;
      awv_q <= 1'b0;    wv_q <= 1'b0;    arv_q <= 1'b0;
      bv_q <= 1'b0;     rv_q <= 1'b0;
      bresp_q <= '0;    rresp_q <= '0;
      worph_q <= 1'b0;  rorph_q <= 1'b0;
      wcnt_q <= '0;     rcnt_q <= '0;
      wto_q <= 1'b0;    rto_q <= 1'b0;
    end else begin
      wst_q <= wst_d;       rst_q <= rst_d;
      awaddr_q <= awaddr_d; araddr_q <= araddr_d;
      wdata_q <= wdata_d;   rdata_q <= rdata_d;  wstrb_q <= wstrb_d;
      awv_q <= awv_d;       wv_q <= wv_d;        arv_q <= arv_d;
      bv_q <= bv_d;         rv_q <= rv_d;
      bresp_q <= bresp_d;   rresp_q <= rresp_d;
      worph_q <= worph_d;   rorph_q <= rorph_d;
      wcnt_q <= wcnt_d;     rcnt_q <= rcnt_d;
      wto_q <= wto_d;       rto_q <= rto_d;
    end
  end

`ifdef VNP4_AXIL_GUARD_STATS_EN
  logic [1:0]  orph_inc;
  logic [16:0] orph_sum;
  assign orph_inc = {1'b0, (wst_q == W_ORPHAN) && m_axi_bvalid}
                  + {1'b0, (rst_q == R_ORPHAN) && m_axi_rvalid};
  assign orph_sum = {1'b0, orphan_cnt} + {15'd0, orph_inc};

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      wr_timeout_cnt <= '0;
      rd_timeout_cnt <= '0;
      orphan_cnt     <= '0;
    end else begin
      if (wto_q && wr_timeout_cnt != 16'hFFFF) wr_timeout_cnt <= wr_timeout_cnt + 16'd1;
      if (rto_q && rd_timeout_cnt != 16'hFFFF) rd_timeout_cnt <= rd_timeout_cnt + 16'd1;
      orphan_cnt <= orph_sum[16] ? 16'hFFFF : orph_sum[15:0];
    end
  end
`endif
endmodule

// File: tb/tb_vnp4_axil_timeout_guard.sv
// Directed bench for vnp4_axil_timeout_guard with TIMEOUT_CYCLES=16: vector table plus reset/concurrency sequences.
module tb_vnp4_axil_timeout_guard;
  localparam int TO = 16;

  logic        axi_aclk = 1'b0, axi_areset = 1'b1;
  logic [31:0] s_axi_awaddr = '0, s_axi_wdata = '0, s_axi_araddr = '0, s_axi_rdata;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_awvalid = 0, s_axi_awready, s_axi_wvalid = 0, s_axi_wready;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready = 0, s_axi_arvalid = 0, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready = 0;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata = '0;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready = 1, m_axi_wvalid, m_axi_wready = 1;
  logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;
  logic        m_axi_bvalid = 0, m_axi_bready, m_axi_arvalid, m_axi_arready = 1;
  logic        m_axi_rvalid = 0, m_axi_rready;
  logic        wr_timeout, rd_timeout;
`ifdef VNP4_AXIL_GUARD_STATS_EN
  logic [15:0] wr_timeout_cnt, rd_timeout_cnt, orphan_cnt;
`endif

  int chk_cnt = 0, pass_cnt = 0;

  vnp4_axil_timeout_guard #(.TIMEOUT_CYCLES(TO)) dut (
    .axi_aclk(axi_aclk), .axi_areset(axi_areset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
`ifdef VNP4_AXIL_GUARD_STATS_EN
    .wr_timeout_cnt(wr_timeout_cnt), .rd_timeout_cnt(rd_timeout_cnt), .orphan_cnt(orphan_cnt),
`endif
    .wr_timeout(wr_timeout), .rd_timeout(rd_timeout)
  );

  always #5 axi_aclk = ~axi_aclk;

  // Cycle numbering: 0 = upstream accept, 1 = m_*valid rises; bcyc = cycle the slave raises its response.
  typedef struct {
    bit          rd;
    logic [31:0] addr, data;
    int          bcyc;
    logic [1:0]  sresp;
    int          hold;
    bit          probe;
    logic [1:0]  eresp;
    logic [31:0] edata;
    bit          eto;
    int          en;
  } vec_t;

  vec_t vt[12];

  function automatic vec_t mk(bit rd, logic [31:0] addr, data, int bcyc, logic [1:0] sresp,
                              int hold, bit probe, logic [1:0] eresp, logic [31:0] edata,
                              bit eto, int en);
    vec_t v;
    v.rd = rd; v.addr = addr; v.data = data; v.bcyc = bcyc; v.sresp = sresp; v.hold = hold;
    v.probe = probe; v.eresp = eresp; v.edata = edata; v.eto = eto; v.en = en;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
                       s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
                       wr_timeout, rd_timeout}, 0);
    chk({nm, "_dat"}, {m_axi_awaddr | m_axi_wdata | m_axi_araddr | s_axi_rdata,
                       m_axi_wstrb, s_axi_bresp, s_axi_rresp}, 0);
  endtask

  task automatic txn(input vec_t v, input string nm);
    int n, first = 0, pulses = 0, to_at = 0;
    bit up_done = 0, b_done = 0, b_hs = 0, up_hs = 0, stable_ok = 1, probe_ok = 1, pr;
    logic [1:0] r0 = '0;
    logic [31:0] d0 = '0;
    @(negedge axi_aclk);
    if (v.rd) begin s_axi_araddr = v.addr; s_axi_arvalid = 1; end
    else begin
      s_axi_awaddr = v.addr; s_axi_wdata = v.data; s_axi_wstrb = 4'b1011;
      s_axi_awvalid = 1; s_axi_wvalid = 1;
    end
    #1 chk({nm, "_accept"}, v.rd ? s_axi_arready : (s_axi_awready & s_axi_wready), 1);
    for (n = 1; n <= 200 && !(up_done && b_done); n++) begin
      @(negedge axi_aclk);
      if (up_hs) up_done = 1;
      if (b_hs) begin
        b_done = 1;
        if (v.rd) m_axi_rvalid = 0; else m_axi_bvalid = 0;
      end
      if (!b_done && n >= v.bcyc) begin
        if (v.rd) begin m_axi_rvalid = 1; m_axi_rresp = v.sresp; m_axi_rdata = v.data; end
        else begin m_axi_bvalid = 1; m_axi_bresp = v.sresp; end
      end
      pr = v.probe && up_done && !b_done;
      if (v.rd) begin s_axi_arvalid = pr; s_axi_rready = first != 0 && n >= first + v.hold && !up_done; end
      else begin
        s_axi_awvalid = pr; s_axi_wvalid = pr;
        s_axi_bready = first != 0 && n >= first + v.hold && !up_done;
      end
      #1;
      if (n == 1) begin
        chk({nm, "_mvalid"}, v.rd ? m_axi_arvalid : (m_axi_awvalid & m_axi_wvalid), 1);
        chk({nm, "_maddr"}, v.rd ? m_axi_araddr : m_axi_awaddr, v.addr);
        if (!v.rd) chk({nm, "_mdata"}, {m_axi_wstrb, m_axi_wdata}, {4'b1011, v.data});
      end
      if (n == 2) chk({nm, "_mvalid_drop"}, v.rd ? m_axi_arvalid : (m_axi_awvalid | m_axi_wvalid), 0);
      if (v.rd ? rd_timeout : wr_timeout) begin pulses++; to_at = n; end
      if ((v.rd ? s_axi_rvalid : s_axi_bvalid) && first == 0) begin
        first = n;
        r0 = v.rd ? s_axi_rresp : s_axi_bresp;
        d0 = s_axi_rdata;
        chk({nm, "_lat"}, n, v.en);
        chk({nm, "_resp"}, r0, v.eresp);
        if (v.rd) chk({nm, "_rdata"}, d0, v.edata);
      end else if ((v.rd ? s_axi_rvalid : s_axi_bvalid) && !up_done) begin
        if ((v.rd ? s_axi_rresp : s_axi_bresp) !== r0 || (v.rd && s_axi_rdata !== d0)) stable_ok = 0;
      end else if (first != 0 && !up_done && !up_hs) stable_ok = 0;
      if (pr && (v.rd ? s_axi_arready : s_axi_awready)) probe_ok = 0;
      b_hs  = v.rd ? (m_axi_rvalid && m_axi_rready) : (m_axi_bvalid && m_axi_bready);
      up_hs = v.rd ? (s_axi_rvalid && s_axi_rready) : (s_axi_bvalid && s_axi_bready);
    end
    chk({nm, "_done"}, {up_done, b_done}, 2'b11);
    chk({nm, "_sv_drop"}, v.rd ? s_axi_rvalid : s_axi_bvalid, 0);
    chk({nm, "_to_pulses"}, pulses, v.eto);
    if (v.eto) chk({nm, "_to_cycle"}, to_at, v.en);
    if (v.hold > 0) chk({nm, "_stable"}, stable_ok, 1);
    if (v.probe) chk({nm, "_blocked"}, probe_ok, 1);
  endtask

  initial begin
    vt[0]  = mk(0, 32'h0000_1000, 32'hA5A5_0001,  4, 2'b00,  0, 0, 2'b00, 0, 0,  5);
    vt[1]  = mk(0, 32'h0000_1004, 32'h0000_0002,  2, 2'b10,  0, 0, 2'b10, 0, 0,  3);
    vt[2]  = mk(0, 32'h0000_1008, 32'h0000_0003,  2, 2'b11,  0, 0, 2'b11, 0, 0,  3);
    vt[3]  = mk(0, 32'h0000_100C, 32'h0000_0004, 16, 2'b01,  0, 0, 2'b01, 0, 0, 17);
    vt[4]  = mk(0, 32'h0000_1010, 32'h0000_0005, 40, 2'b00,  0, 1, 2'b10, 0, 1, 17);
    vt[5]  = mk(0, 32'h0000_1014, 32'h0000_0006, 17, 2'b00,  0, 0, 2'b10, 0, 1, 17);
    vt[6]  = mk(1, 32'h0000_0020, 32'h1234_5678,  3, 2'b00,  0, 0, 2'b00, 32'h1234_5678, 0,  4);
    vt[7]  = mk(1, 32'h0000_0024, 32'h0BAD_BEEF, 30, 2'b00,  0, 1, 2'b10, 32'hDEAD_10CC, 1, 17);
    vt[8]  = mk(1, 32'h0000_0028, 32'hCAFE_F00D, 16, 2'b11,  0, 0, 2'b11, 32'hCAFE_F00D, 0, 17);
    vt[9]  = mk(0, 32'h0000_1018, 32'h0000_0007,  3, 2'b00, 10, 0, 2'b00, 0, 0,  4);
    vt[10] = mk(0, 32'h0000_1020, 32'h0000_000A,  5, 2'b00, 10, 0, 2'b00, 0, 0,  6);
    vt[11] = mk(1, 32'h0000_0030, 32'h5555_AAAA,  3, 2'b01,  0, 0, 2'b01, 32'h5555_AAAA, 0, 4);

    // Upstream valids held high during reset: readies must stay low.
    s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_arvalid = 1;
    repeat (3) @(negedge axi_aclk);
    chk_zero("reset");
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    @(negedge axi_aclk);
    axi_areset = 0;

    for (int i = 0; i < 10; i++) txn(vt[i], $sformatf("v%0d", i));

    fork
      txn(vt[10], "cc_wr");
      txn(vt[11], "cc_rd");
    join

    // Async reset mid-flight while the write is waiting on the slave.
    @(negedge axi_aclk);
    s_axi_awaddr = 32'h0000_2000; s_axi_wdata = 32'h1111_2222; s_axi_awvalid = 1; s_axi_wvalid = 1;
    @(negedge axi_aclk);
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    #1 chk("rst_pre_mvalid", m_axi_awvalid, 1);
    s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_arvalid = 1;
    #1 axi_areset = 1;
    #1 chk_zero("rst_async");
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    repeat (2) @(negedge axi_aclk);
    axi_areset = 0;
    txn(vt[0], "post_rst");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected finish");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
    $fatal(1, "watchdog");
  end
endmodule
